// File: rtl/bus_demultiplexer_pkg.sv
// Shared types and constants for the bus demultiplexer.
// BUS_DEMUX_ERR_DATA is the payload of a synthetic read response (BUS_DEMUX_TIMEOUT_EN builds).
package bus_demultiplexer_pkg;

    // Sliced down to DATA_WIDTH by the user; wide enough for any sensible bus.
    localparam logic [1023:0] BUS_DEMUX_ERR_DATA = '1;

    typedef enum logic [1:0] {
        PEND_HOLD,
        PEND_INC,
        PEND_DEC
    } pend_op_e;

endpackage

// File: rtl/bus_demultiplexer_if.sv
// Upstream slave port plus the broadcast/per-channel downstream ports of the demultiplexer.
// Channel k occupies slice CHANNELS-1-k of every packed per-channel bus.
interface bus_demultiplexer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 4
);
    logic [ADDR_WIDTH-1:0]          s_address;
    logic                           s_read;
    logic                           s_write;
    logic [DATA_WIDTH-1:0]          s_writedata;
    logic [DATA_WIDTH/8-1:0]        s_byteenable;
    logic                           s_waitrequest;
    logic [DATA_WIDTH-1:0]          s_readdata;
    logic                           s_readdatavalid;

    logic [ADDR_WIDTH-1:0]          m_address;
    logic [DATA_WIDTH-1:0]          m_writedata;
    logic [DATA_WIDTH/8-1:0]        m_byteenable;
    logic [CHANNELS-1:0]            m_read;
    logic [CHANNELS-1:0]            m_write;
    logic [CHANNELS-1:0]            m_waitrequest;
    logic [CHANNELS*DATA_WIDTH-1:0] m_readdata;
    logic [CHANNELS-1:0]            m_readdatavalid;

    // The demultiplexer itself.
    modport slave (
        input  s_address, s_read, s_write, s_writedata, s_byteenable,
        output s_waitrequest, s_readdata, s_readdatavalid,
        output m_address, m_writedata, m_byteenable, m_read, m_write,
        input  m_waitrequest, m_readdata, m_readdatavalid
    );

    // The environment: upstream requester and downstream slaves.
    modport master (
        output s_address, s_read, s_write, s_writedata, s_byteenable,
        input  s_waitrequest, s_readdata, s_readdatavalid,
        input  m_address, m_writedata, m_byteenable, m_read, m_write,
        output m_waitrequest, m_readdata, m_readdatavalid
    );
endinterface

// File: rtl/bus_demux_mux.sv
// N-way multiplexer over a packed bus; selection k picks slice N-1-k (channel 0 = MSB slice).
module bus_demux_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N*WIDTH-1:0] data,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   y
);
    always_comb begin
        // NOTE: default first, so every path assigns y and no latch is inferred.
        y = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k)) y = data[(N-1-k)*WIDTH +: WIDTH];
        end
    end
endmodule

// File: rtl/bus_demux_read_tracker.sv
// Outstanding-read bookkeeping: count, owning channel and, with BUS_DEMUX_TIMEOUT_EN,
// a watchdog that emits a one-cycle timeout pulse when the owning slave stays silent.
module bus_demux_read_tracker
    import bus_demultiplexer_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int MAX_PENDING    = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CH_W  = $clog2(CHANNELS),
    localparam int CNT_W = $clog2(MAX_PENDING + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             accept,
    input  logic [CH_W-1:0]  ch,
    input  logic             rsp,
    output logic [CNT_W-1:0] pend_cnt,
    output logic [CH_W-1:0]  pend_ch,
    output logic             timeout
);
    pend_op_e op;
    logic     resp_any;

    assign resp_any = rsp | timeout;

    always_comb begin
        case ({accept, resp_any})
            2'b10:   op = PEND_INC;
            2'b01:   op = PEND_DEC;
            default: op = PEND_HOLD;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_cnt <= '0;
            pend_ch  <= '0;
        end else begin
            case (op)
                PEND_INC: pend_cnt <= pend_cnt + CNT_W'(1);
                PEND_DEC: pend_cnt <= pend_cnt - CNT_W'(1);
                default:  pend_cnt <= pend_cnt;
            endcase
            if (accept) pend_ch <= ch;
        end
    end

`ifdef BUS_DEMUX_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);

    logic [TIMER_W-1:0] timer;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (accept || resp_any || pend_cnt == '0) begin
            timer <= '0;
        end else begin
            timer <= timer + TIMER_W'(1);
        end
    end

    // A real response in the same cycle always wins over the synthetic one.
    assign timeout = (pend_cnt != '0) && !rsp && (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif
endmodule

// File: rtl/bus_demultiplexer.sv
// One Avalon-MM slave port fanned out to CHANNELS master ports, decoded from the top address bits.
// Reads to a different channel stall until earlier reads drain; BUS_DEMUX_TIMEOUT_EN adds a read watchdog.
module bus_demultiplexer
    import bus_demultiplexer_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CHANNELS       = 4,
    parameter int MAX_PENDING    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                 clock,
    input logic                 reset_n,
    bus_demultiplexer_if.slave  bus
);
    localparam int CH_W  = $clog2(CHANNELS);
    localparam int CNT_W = $clog2(MAX_PENDING + 1);
    localparam logic [CHANNELS-1:0] CH0_SEL = {1'b1, {(CHANNELS-1){1'b0}}};

    logic [CH_W-1:0]       ch;
    logic [CH_W-1:0]       pend_ch;
    logic [CNT_W-1:0]      pend_cnt;
    logic [CHANNELS-1:0]   ch_sel;
    logic [CHANNELS-1:0]   pend_sel;
    logic                  stall;
    logic                  wait_ch;
    logic                  accept;
    logic                  rsp;
    logic                  timeout;
    logic [DATA_WIDTH-1:0] rsp_data;

    assign ch       = bus.s_address[ADDR_WIDTH-1 -: CH_W];
    assign ch_sel   = CH0_SEL >> ch;
    assign pend_sel = CH0_SEL >> pend_ch;

    // Registered state only: a response landing this cycle does not release the stall.
    assign stall   = bus.s_read &&
                     ((pend_cnt != '0 && ch != pend_ch) || pend_cnt == CNT_W'(MAX_PENDING));
    assign wait_ch = |(bus.m_waitrequest & ch_sel);
    assign accept  = reset_n && bus.s_read && !stall && !wait_ch;
    assign rsp     = (pend_cnt != '0) && |(bus.m_readdatavalid & pend_sel);

    assign bus.m_address    = bus.s_address;
    assign bus.m_writedata  = bus.s_writedata;
    assign bus.m_byteenable = bus.s_byteenable;
    assign bus.m_read       = (reset_n && bus.s_read && !stall) ? ch_sel : '0;
    assign bus.m_write      = (reset_n && bus.s_write) ? ch_sel : '0;

    assign bus.s_waitrequest   = !reset_n || stall || wait_ch;
    assign bus.s_readdatavalid = reset_n && (rsp || timeout);
    assign bus.s_readdata      = timeout ? BUS_DEMUX_ERR_DATA[DATA_WIDTH-1:0] : rsp_data;

    bus_demux_read_tracker #(
        .CHANNELS       (CHANNELS),
        .MAX_PENDING    (MAX_PENDING),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tracker (
        .clock    (clock),
        .reset_n  (reset_n),
        .accept   (accept),
        .ch       (ch),
        .rsp      (rsp),
        .pend_cnt (pend_cnt),
        .pend_ch  (pend_ch),
        .timeout  (timeout)
    );

    bus_demux_mux #(
        .WIDTH (DATA_WIDTH),
        .N     (CHANNELS)
    ) u_rsp_mux (
        .data (bus.m_readdata),
        .sel  (pend_ch),
        .y    (rsp_data)
    );
endmodule

// File: tb/tb_bus_demultiplexer.sv
// Directed bench for bus_demultiplexer: decode table plus multi-cycle read-ordering sequences.
// Expectations for the watchdog sequence depend on BUS_DEMUX_TIMEOUT_EN.
module tb_bus_demultiplexer;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int NCH  = 4;
    localparam int MAXP = 4;
    localparam int TMO  = 16;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    bus_demultiplexer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHANNELS(NCH)) bus ();

    bus_demultiplexer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHANNELS(NCH),
        .MAX_PENDING(MAXP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [3:0]  mwait;
        logic [3:0]  exp_mread;
        logic [3:0]  exp_mwrite;
        logic        exp_swait;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packed downstream read-data bus: channel c carries v, the others carry tagged filler.
    function automatic logic [NCH*DW-1:0] rd_bus(input int c, input logic [DW-1:0] v);
        logic [NCH*DW-1:0] r;
        for (int k = 0; k < NCH; k++)
            r[(NCH-1-k)*DW +: DW] = (k == c) ? v : (32'hDEAD_0000 | 32'(k));
        return r;
    endfunction

    task automatic idle();
        bus.s_address       = '0;
        bus.s_read          = 1'b0;
        bus.s_write         = 1'b0;
        bus.s_writedata     = '0;
        bus.s_byteenable    = '0;
        bus.m_waitrequest   = '0;
        bus.m_readdata      = '0;
        bus.m_readdatavalid = '0;
    endtask

    task automatic set_read(input logic [31:0] a);
        bus.s_address = a;
        bus.s_read    = 1'b1;
    endtask

    task automatic respond(input int c, input logic [31:0] v);
        bus.m_readdatavalid = 4'b1000 >> c;
        bus.m_readdata      = rd_bus(c, v);
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int got;
        int cnt;
        logic [31:0] gdata;

        vecs[0] = '{32'h4000_0010, 1'b0, 1'b1, 32'h1234_5678, 4'hF, 4'b0000, 4'b0000, 4'b0100, 1'b0};
        vecs[1] = '{32'h4000_0010, 1'b0, 1'b1, 32'h1234_5678, 4'hF, 4'b0100, 4'b0000, 4'b0100, 1'b1};
        vecs[2] = '{32'h4000_0010, 1'b0, 1'b1, 32'h1234_5678, 4'hF, 4'b1011, 4'b0000, 4'b0100, 1'b0};
        vecs[3] = '{32'hC000_0004, 1'b0, 1'b1, 32'hCAFE_F00D, 4'h3, 4'b0000, 4'b0000, 4'b0001, 1'b0};
        vecs[4] = '{32'h0000_0008, 1'b0, 1'b1, 32'h0000_0000, 4'h1, 4'b1000, 4'b0000, 4'b1000, 1'b1};
        vecs[5] = '{32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 4'hF, 4'b1000, 4'b1000, 4'b0000, 1'b1};
        vecs[6] = '{32'h8000_0000, 1'b1, 1'b0, 32'h0000_0000, 4'hF, 4'b0010, 4'b0010, 4'b0000, 1'b1};
        vecs[7] = '{32'hBFFF_FFFC, 1'b1, 1'b0, 32'h0000_0000, 4'hF, 4'b0010, 4'b0010, 4'b0000, 1'b1};
        vecs[8] = '{32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 4'b0000, 4'b0000, 4'b0000, 1'b0};

        // Reset: outputs forced quiet even with a live request and stray responses.
        reset_n = 1'b0;
        idle();
        set_read(32'h8000_0000);
        bus.m_readdatavalid = 4'b1111;
        next(); next();
        sample();
        check("rst_swait", bus.s_waitrequest, 1'b1);
        check("rst_mread", bus.m_read, 4'b0000);
        check("rst_mwrite", bus.m_write, 4'b0000);
        check("rst_rdv", bus.s_readdatavalid, 1'b0);
        check("rst_pend", dut.pend_cnt, 0);
        idle();
        next();
        reset_n = 1'b1;
        next();

        // Decode / steering table, no read ever accepted.
        for (int i = 0; i < 9; i++) begin
            idle();
            bus.s_address     = vecs[i].addr;
            bus.s_read        = vecs[i].rd;
            bus.s_write       = vecs[i].wr;
            bus.s_writedata   = vecs[i].wdata;
            bus.s_byteenable  = vecs[i].be;
            bus.m_waitrequest = vecs[i].mwait;
            sample();
            check($sformatf("vec%0d_mread", i), bus.m_read, vecs[i].exp_mread);
            check($sformatf("vec%0d_mwrite", i), bus.m_write, vecs[i].exp_mwrite);
            check($sformatf("vec%0d_swait", i), bus.s_waitrequest, vecs[i].exp_swait);
            check($sformatf("vec%0d_maddr", i), bus.m_address, vecs[i].addr);
            check($sformatf("vec%0d_mwdata", i), bus.m_writedata, vecs[i].wdata);
            check($sformatf("vec%0d_mbe", i), bus.m_byteenable, vecs[i].be);
            check($sformatf("vec%0d_pend", i), dut.pend_cnt, 0);
            next();
        end

        // Three back-to-back ch2 reads, answered in order three cycles later.
        for (int i = 0; i < 3; i++) begin
            idle();
            set_read(32'h8000_0000 + 32'(4 * i));
            sample();
            check("t2_mread", bus.m_read, 4'b0010);
            check("t2_swait", bus.s_waitrequest, 1'b0);
            check("t2_pend_up", dut.pend_cnt, i);
            next();
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            respond(2, 32'hA + 32'(i));
            sample();
            check("t2_rdv", bus.s_readdatavalid, 1'b1);
            check("t2_rdata", bus.s_readdata, 32'hA + 32'(i));
            check("t2_pend_down", dut.pend_cnt, 3 - i);
            next();
        end
        idle();
        sample();
        check("t2_rdv_end", bus.s_readdatavalid, 1'b0);
        check("t2_pend_end", dut.pend_cnt, 0);
        next();

        // ch0 read pending blocks a ch3 read until the cycle after its response.
        idle();
        set_read(32'h0000_0000);
        sample();
        check("t3_mread_ch0", bus.m_read, 4'b1000);
        next();
        for (int i = 0; i < 2; i++) begin
            idle();
            set_read(32'hC000_0000);
            sample();
            check("t3_stall_swait", bus.s_waitrequest, 1'b1);
            check("t3_stall_mread", bus.m_read, 4'b0000);
            next();
        end
        idle();
        set_read(32'hC000_0000);
        respond(0, 32'h1111_0000);
        sample();
        check("t3_rsp_rdv", bus.s_readdatavalid, 1'b1);
        check("t3_rsp_data", bus.s_readdata, 32'h1111_0000);
        check("t3_rsp_swait", bus.s_waitrequest, 1'b1);
        check("t3_rsp_mread", bus.m_read, 4'b0000);
        next();
        idle();
        set_read(32'hC000_0000);
        sample();
        check("t3_issue_mread", bus.m_read, 4'b0001);
        check("t3_issue_swait", bus.s_waitrequest, 1'b0);
        next();
        idle();
        sample();
        check("t3_pend_ch3", dut.pend_cnt, 1);
        next();
        idle();
        respond(3, 32'h3333_0003);
        sample();
        check("t3_ch3_data", bus.s_readdata, 32'h3333_0003);
        next();
        idle();
        sample();
        check("t3_pend_end", dut.pend_cnt, 0);
        next();

        // Fill to MAX_PENDING, stall the fifth, then accept+response in one cycle.
        for (int i = 0; i < 4; i++) begin
            idle();
            set_read(32'h4000_0000 + 32'(4 * i));
            sample();
            check("t4_fill_swait", bus.s_waitrequest, 1'b0);
            next();
        end
        idle();
        set_read(32'h4000_0010);
        sample();
        check("t4_full_pend", dut.pend_cnt, 4);
        check("t4_full_swait", bus.s_waitrequest, 1'b1);
        check("t4_full_mread", bus.m_read, 4'b0000);
        next();
        idle();
        respond(1, 32'h4444_0000);
        sample();
        check("t4_rsp0", bus.s_readdata, 32'h4444_0000);
        next();
        idle();
        set_read(32'h4000_0010);
        respond(1, 32'h4444_0001);
        sample();
        check("t4_both_pend", dut.pend_cnt, 3);
        check("t4_both_swait", bus.s_waitrequest, 1'b0);
        check("t4_both_mread", bus.m_read, 4'b0100);
        check("t4_both_rdv", bus.s_readdatavalid, 1'b1);
        next();
        for (int i = 0; i < 3; i++) begin
            idle();
            respond(1, 32'h4444_0002 + 32'(i));
            sample();
            check("t4_drain_pend", dut.pend_cnt, 3 - i);
            check("t4_drain_data", bus.s_readdata, 32'h4444_0002 + 32'(i));
            next();
        end
        idle();
        sample();
        check("t4_pend_end", dut.pend_cnt, 0);
        next();

        // Stray responses are never forwarded.
        idle();
        respond(1, 32'h5555_0001);
        sample();
        check("t5_stray_idle_rdv", bus.s_readdatavalid, 1'b0);
        check("t5_stray_idle_pend", dut.pend_cnt, 0);
        next();
        idle();
        set_read(32'h0000_0040);
        next();
        idle();
        respond(2, 32'h5555_0002);
        sample();
        check("t5_stray_ch_rdv", bus.s_readdatavalid, 1'b0);
        check("t5_stray_ch_pend", dut.pend_cnt, 1);
        next();
        idle();
        respond(0, 32'h5555_0000);
        sample();
        check("t5_real_rdv", bus.s_readdatavalid, 1'b1);
        check("t5_real_data", bus.s_readdata, 32'h5555_0000);
        next();

        // Unanswered ch3 read, then reset while a read is outstanding.
        idle();
        set_read(32'hC000_0000);
        sample();
        check("t6_mread", bus.m_read, 4'b0001);
        check("t6_swait", bus.s_waitrequest, 1'b0);
        next();
        idle();
`ifdef BUS_DEMUX_TIMEOUT_EN
        got = 0;
        gdata = '0;
        for (int k = 1; k <= 40; k++) begin
            sample();
            if (bus.s_readdatavalid) begin
                got = k;
                gdata = bus.s_readdata;
                break;
            end
            next();
        end
        check("t6_timeout_latency", got, 16);
        check("t6_timeout_data", gdata, 32'hFFFF_FFFF);
        next();
        sample();
        check("t6_timeout_pend", dut.pend_cnt, 0);
        next();
`else
        cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            sample();
            if (bus.s_readdatavalid) cnt++;
            next();
        end
        check("t6_no_rsp", cnt, 0);
        sample();
        check("t6_pend_hold", dut.pend_cnt, 1);
        next();
`endif
        idle();
        set_read(32'hC000_0000);
        next();
        idle();
        sample();
`ifdef BUS_DEMUX_TIMEOUT_EN
        check("t6_pre_reset_pend", dut.pend_cnt, 1);
`else
        check("t6_pre_reset_pend", dut.pend_cnt, 2);
`endif
        reset_n = 1'b0;
        #1;
        check("t6_reset_pend", dut.pend_cnt, 0);
        check("t6_reset_swait", bus.s_waitrequest, 1'b1);
        next();
        reset_n = 1'b1;
        next();
        idle();
        respond(3, 32'h6666_0003);
        sample();
        check("t6_late_rdv", bus.s_readdatavalid, 1'b0);
        check("t6_late_pend", dut.pend_cnt, 0);
        next();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
